// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bus for the BCD converter
interface bin_to_bcd_seq_if #(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [N_DIGITS*4-1:0] bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
module bin_to_bcd_seq #(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int BCD_W = N_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(pow10(N_DIGITS) - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_scratch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    // Each digit is corrected from the pre-step value, independently of its neighbours.
    adj = scratch_q;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
    end
    step_scratch = {adj[BCD_W-2:0], shift_q[BIN_W-1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CONVERT;
          shift_d    = bus.bin_in;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (bus.bin_in > MAX_VAL);
        end
      end
      CONVERT: begin
        scratch_d = step_scratch;
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          bcd_d   = ovf_pend_q ? {BCD_W{1'b1}} : step_scratch;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == CONVERT);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd_out  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
  localparam int BIN_W    = 14;
  localparam int N_DIGITS = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          x;
    if (v > 9999) return 16'hFFFF;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (16'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_conv(input int v, input string tag, input bit check_busy);
    int lat;
    int busy_cnt;
    bus.bin_in = BIN_W'(v);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = BIN_W'($urandom);
    lat = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 30) begin
      tick();
      lat++;
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, lat, 14);
    if (check_busy) check({tag, "_busy_cycles"}, busy_cnt, 14);
    check({tag, "_bcd"}, {16'h0, bus.bcd_out}, {16'h0, ref_bcd(v)});
    check({tag, "_ovf"}, {31'h0, bus.overflow}, {31'h0, v > 9999});
    tick();
    check({tag, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    int n;
    int ndone;
    int first_lat;
    int changes;
    int v;

    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) tick();
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_ovf",  {31'h0, bus.overflow}, 32'h0);
    check("rst_bcd",  {16'h0, bus.bcd_out}, 32'h0);
    reset = 1'b0;
    tick();

    do_conv(0, "zero", 1'b1);
    do_conv(1234, "c1234", 1'b0);
    do_conv(9999, "c9999", 1'b0);
    do_conv(507, "c507", 1'b0);
    do_conv(10000, "c10000", 1'b0);
    do_conv(16383, "c16383", 1'b0);
    do_conv(42, "c42", 1'b0);

    // Starts issued mid-conversion must be ignored.
    bus.bin_in = 14'd1234;
    bus.start  = 1'b1;
    tick();
    ndone = 0;
    first_lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3 || k == 13) begin
        bus.start  = 1'b1;
        bus.bin_in = 14'd8888;
      end else begin
        bus.start  = 1'b0;
      end
      tick();
      if (bus.done) begin
        ndone++;
        if (first_lat == 0) first_lat = k;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_latency", first_lat, 14);
    check("ign_bcd", {16'h0, bus.bcd_out}, 32'h1234);
    check("ign_busy", {31'h0, bus.busy}, 32'h0);

    // Held start gives back-to-back conversions.
    bus.bin_in = 14'd1234;
    bus.start  = 1'b1;
    tick();
    n = 0;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    check("held_lat1", n, 14);
    check("held_bcd1", {16'h0, bus.bcd_out}, 32'h1234);
    bus.bin_in = 14'd5678;
    n = 0;
    changes = 0;
    do begin
      tick();
      n++;
      if (!bus.done && bus.bcd_out !== 16'h1234) changes++;
    end while (!bus.done && n < 30);
    bus.start = 1'b0;
    check("held_period", n, 15);
    check("held_stable", changes, 0);
    check("held_bcd2", {16'h0, bus.bcd_out}, 32'h5678);
    repeat (20) tick();

    // Reset mid-conversion aborts without a done pulse.
    do_conv(4321, "c4321", 1'b0);
    bus.bin_in = 14'd9999;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_bcd",  {16'h0, bus.bcd_out}, 32'h0);
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_conv(77, "c77", 1'b0);

    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(16383, 0)) : int'($urandom_range(9999, 0));
      do_conv(v, $sformatf("rand%0d_%0d", i, v), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
